// File: rtl/control_unit_if.sv
// control_unit_if -- bundle between the sequencer and the 8-bit data path.
//   IR, CCR_Result        : data path -> sequencer (opcode, NZVC flags)
//   *_Load, PC_Inc        : register enables
//   ALU_Sel, Bus1/2_Sel   : data path steering
//   write                 : memory write strobe (address MAR, data Bus1)
// Modport ctrl is the sequencer side; dp is the data path side.
interface control_unit_if;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load;
  logic [2:0] ALU_Sel;
  logic [1:0] Bus1_Sel;
  logic [1:0] Bus2_Sel;
  logic       write;

  modport ctrl (
    input  IR, CCR_Result,
    output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
           ALU_Sel, Bus1_Sel, Bus2_Sel, write
  );

  modport dp (
    output IR, CCR_Result,
    input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
           ALU_Sel, Bus1_Sel, Bus2_Sel, write
  );
endinterface

// File: rtl/control_unit.sv
// control_unit -- Moore sequencer for the 8-bit CPU data path.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset, forces S_FETCH_0
//   cu    : control_unit_if.ctrl (opcode/flags in, data path controls out)
// Every instruction starts with a 3-state fetch and a decode state. Outputs
// depend on state only; the single exception is S_BR_5, where the branch
// condition is taken live from CCR_Result.
module control_unit (
  input  logic           clock,
  input  logic           reset,
  control_unit_if.ctrl   cu
);

  typedef enum logic [3:0] {
    S_FETCH_0  = 4'd0,
    S_FETCH_1  = 4'd1,
    S_FETCH_2  = 4'd2,
    S_DECODE_3 = 4'd3,
    S_OP_4     = 4'd4,
    S_OP_5     = 4'd5,
    S_LDI_6    = 4'd6,
    S_DIR_6    = 4'd7,
    S_DIR_7    = 4'd8,
    S_ALU_4    = 4'd9,
    S_BR_5     = 4'd10
  } state_t;

  state_t state, nxt;

  logic is_ldi, is_dir, is_st, is_alu, is_br, br_taken;
  logic z_f, c_f;
  logic unused_flags;

  assign z_f = cu.CCR_Result[2];
  assign c_f = cu.CCR_Result[0];
  // N and V are not consulted by any branch in this instruction set.
  assign unused_flags = cu.CCR_Result[3] ^ cu.CCR_Result[1];

  // Opcode classes; IR holds from S_DECODE_3 through the end of the instruction.
  assign is_ldi = (cu.IR == 8'h86) || (cu.IR == 8'h88);
  assign is_st  = (cu.IR == 8'h96) || (cu.IR == 8'h97);
  assign is_dir = (cu.IR == 8'h87) || (cu.IR == 8'h89) || is_st;
  assign is_alu = (cu.IR >= 8'h42) && (cu.IR <= 8'h49);
  assign is_br  = (cu.IR == 8'h20) || (cu.IR == 8'h23) || (cu.IR == 8'h24) ||
                  (cu.IR == 8'h27) || (cu.IR == 8'h28);

  always_comb begin
    br_taken = 1'b0;
    case (cu.IR)
      8'h20:   br_taken = 1'b1;
      8'h23:   br_taken = z_f;
      8'h24:   br_taken = ~z_f;
      8'h27:   br_taken = c_f;
      8'h28:   br_taken = ~c_f;
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_FETCH_0;
    else        state <= nxt;
  end

  always_comb begin
    nxt         = S_FETCH_0;
    cu.IR_Load  = 1'b0;
    cu.MAR_Load = 1'b0;
    cu.PC_Load  = 1'b0;
    cu.PC_Inc   = 1'b0;
    cu.A_Load   = 1'b0;
    cu.B_Load   = 1'b0;
    cu.CCR_Load = 1'b0;
    cu.ALU_Sel  = 3'b000;
    cu.Bus1_Sel = 2'b00;
    cu.Bus2_Sel = 2'b00;
    cu.write    = 1'b0;
    case (state)
      S_FETCH_0: begin
        cu.Bus2_Sel = 2'b01;
        cu.MAR_Load = 1'b1;
        nxt         = S_FETCH_1;
      end
      S_FETCH_1: begin
        cu.PC_Inc = 1'b1;
        nxt       = S_FETCH_2;
      end
      S_FETCH_2: begin
        cu.Bus2_Sel = 2'b10;
        cu.IR_Load  = 1'b1;
        nxt         = S_DECODE_3;
      end
      S_DECODE_3: begin
        if (is_ldi || is_dir || is_br) nxt = S_OP_4;
        else if (is_alu)               nxt = S_ALU_4;
        else                           nxt = S_FETCH_0;
      end
      S_OP_4: begin
        cu.Bus2_Sel = 2'b01;
        cu.MAR_Load = 1'b1;
        nxt         = is_br ? S_BR_5 : S_OP_5;
      end
      S_OP_5: begin
        cu.PC_Inc = 1'b1;
        nxt       = is_ldi ? S_LDI_6 : S_DIR_6;
      end
      S_LDI_6: begin
        cu.Bus2_Sel = 2'b10;
        cu.A_Load   = (cu.IR == 8'h86);
        cu.B_Load   = (cu.IR == 8'h88);
      end
      S_DIR_6: begin
        cu.Bus2_Sel = 2'b10;
        cu.MAR_Load = 1'b1;
        nxt         = S_DIR_7;
      end
      S_DIR_7: begin
        if (is_st) begin
          cu.write    = 1'b1;
          cu.Bus1_Sel = (cu.IR == 8'h96) ? 2'b01 : 2'b10;
        end else begin
          cu.Bus2_Sel = 2'b10;
          cu.A_Load   = (cu.IR == 8'h87);
          cu.B_Load   = (cu.IR == 8'h89);
        end
      end
      S_ALU_4: begin
        cu.CCR_Load = 1'b1;
        case (cu.IR)
          8'h42:   begin cu.ALU_Sel = 3'b000; cu.Bus1_Sel = 2'b01; cu.A_Load = 1'b1; end
          8'h43:   begin cu.ALU_Sel = 3'b001; cu.Bus1_Sel = 2'b01; cu.A_Load = 1'b1; end
          8'h44:   begin cu.ALU_Sel = 3'b010; cu.Bus1_Sel = 2'b01; cu.A_Load = 1'b1; end
          8'h45:   begin cu.ALU_Sel = 3'b011; cu.Bus1_Sel = 2'b01; cu.A_Load = 1'b1; end
          8'h46:   begin cu.ALU_Sel = 3'b100; cu.Bus1_Sel = 2'b01; cu.A_Load = 1'b1; end
          8'h47:   begin cu.ALU_Sel = 3'b100; cu.Bus1_Sel = 2'b10; cu.B_Load = 1'b1; end
          8'h48:   begin cu.ALU_Sel = 3'b101; cu.Bus1_Sel = 2'b01; cu.A_Load = 1'b1; end
          8'h49:   begin cu.ALU_Sel = 3'b101; cu.Bus1_Sel = 2'b10; cu.B_Load = 1'b1; end
          default: cu.ALU_Sel = 3'b000;
        endcase
      end
      S_BR_5: begin
        // Taken loads PC from the operand byte; not taken just skips it.
        if (is_br && br_taken) begin
          cu.Bus2_Sel = 2'b10;
          cu.PC_Load  = 1'b1;
        end else begin
          cu.PC_Inc = 1'b1;
        end
      end
      default: nxt = S_FETCH_0;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit -- directed table plus randomized instruction stream for
// control_unit, each cycle checked against a cycle-indexed instruction model.
module tb_control_unit;

  // {ir,mar,pcl,pci,a,b,ccr} alu bus1 bus2 write
  typedef struct packed {
    logic       ir_load, mar_load, pc_load, pc_inc, a_load, b_load, ccr_load;
    logic [2:0] alu_sel;
    logic [1:0] bus1, bus2;
    logic       write;
  } outs_t;

  typedef struct {
    logic [7:0] ir;
    logic [3:0] ccr;
    int         len;
    int         chk_k;
    outs_t      chk;
  } vec_t;

  logic clock, reset;
  control_unit_if bus();

  control_unit dut (.clock(clock), .reset(reset), .cu(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;
  int wr_seen = 0, wr_exp = 0;

  always @(negedge clock) if (bus.write === 1'b1) wr_seen++;

  function automatic outs_t mk(logic [6:0] ld, logic [2:0] alu, logic [1:0] b1,
                               logic [1:0] b2, logic wr);
    return {ld, alu, b1, b2, wr};
  endfunction

  function automatic outs_t dut_out();
    return {bus.IR_Load, bus.MAR_Load, bus.PC_Load, bus.PC_Inc, bus.A_Load,
            bus.B_Load, bus.CCR_Load, bus.ALU_Sel, bus.Bus1_Sel, bus.Bus2_Sel,
            bus.write};
  endfunction

  // Instruction length in cycles, from the opcode class.
  function automatic int exp_len(logic [7:0] op);
    if (op == 8'h86 || op == 8'h88)                              return 7;
    if (op == 8'h87 || op == 8'h89 || op == 8'h96 || op == 8'h97) return 8;
    if (op >= 8'h42 && op <= 8'h49)                              return 5;
    if (op == 8'h20 || op == 8'h23 || op == 8'h24 || op == 8'h27 || op == 8'h28)
                                                                 return 6;
    return 4;
  endfunction

  // Expected controls in cycle k (0-based) of instruction op.
  function automatic outs_t exp_out(logic [7:0] op, logic [3:0] ccr, int k);
    outs_t o = '0;
    int    len = exp_len(op);
    int    idx;
    logic  taken;
    if (k == 0 || (k == 4 && len != 5)) begin o.mar_load = 1; o.bus2 = 2'b01; end
    else if (k == 1) o.pc_inc = 1;
    else if (k == 2) begin o.ir_load = 1; o.bus2 = 2'b10; end
    else if (k == 4) begin  // ALU
      idx = int'(op) - 'h42;
      o.ccr_load = 1;
      o.alu_sel  = (idx < 4) ? 3'(idx) : ((idx < 6) ? 3'd4 : 3'd5);
      if (op == 8'h47 || op == 8'h49) begin o.bus1 = 2'b10; o.b_load = 1; end
      else                            begin o.bus1 = 2'b01; o.a_load = 1; end
    end else if (k == 5 && len == 6) begin  // branch resolve
      case (op)
        8'h20:   taken = 1;
        8'h23:   taken = ccr[2];
        8'h24:   taken = !ccr[2];
        8'h27:   taken = ccr[0];
        default: taken = !ccr[0];
      endcase
      if (taken) begin o.pc_load = 1; o.bus2 = 2'b10; end
      else o.pc_inc = 1;
    end else if (k == 5) o.pc_inc = 1;
    else if (k == 6 && len == 7) begin
      o.bus2 = 2'b10;
      if (op == 8'h86) o.a_load = 1; else o.b_load = 1;
    end else if (k == 6) begin o.bus2 = 2'b10; o.mar_load = 1; end
    else if (k == 7) begin
      if (op == 8'h96)      begin o.write = 1; o.bus1 = 2'b01; end
      else if (op == 8'h97) begin o.write = 1; o.bus1 = 2'b10; end
      else begin
        o.bus2 = 2'b10;
        if (op == 8'h87) o.a_load = 1; else o.b_load = 1;
      end
    end
    return o;
  endfunction

  task automatic check(string nm, outs_t act, outs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Runs cycles start_k..len-1 of op; starts and ends on a negedge with the
  // DUT expected in the first state of the instruction / the next one.
  task automatic run_instr(logic [7:0] op, logic [3:0] ccr, int len, int start_k,
                           bit rnd_ccr, bit use_chk, int chk_k, outs_t chk_o);
    outs_t act;
    bus.IR = op;
    bus.CCR_Result = ccr;
    for (int k = start_k; k < len; k++) begin
      if (rnd_ccr) bus.CCR_Result = 4'($urandom);
      #1;
      act = dut_out();
      check($sformatf("ir%h_k%0d", op, k), act, exp_out(op, bus.CCR_Result, k));
      if (use_chk && k == chk_k) check($sformatf("tbl_ir%h_k%0d", op, k), act, chk_o);
      @(posedge clock);
      @(negedge clock);
    end
    if ((op == 8'h96 || op == 8'h97) && len == 8) wr_exp++;
  endtask

  localparam outs_t F0 = {7'b0100000, 3'b000, 2'b00, 2'b01, 1'b0};

  vec_t tbl[$];
  logic [7:0] valid_ops [19];
  logic [7:0] op;

  initial begin
    tbl.push_back('{8'h86, 4'h0, 7, 6, mk(7'b0000100, 3'b000, 2'b00, 2'b10, 0)});
    tbl.push_back('{8'h96, 4'h0, 8, 7, mk(7'b0000000, 3'b000, 2'b01, 2'b00, 1)});
    tbl.push_back('{8'h96, 4'h0, 8, 6, mk(7'b0100000, 3'b000, 2'b00, 2'b10, 0)});
    tbl.push_back('{8'h23, 4'h4, 6, 5, mk(7'b0010000, 3'b000, 2'b00, 2'b10, 0)});
    tbl.push_back('{8'h23, 4'h0, 6, 5, mk(7'b0001000, 3'b000, 2'b00, 2'b00, 0)});
    tbl.push_back('{8'h43, 4'h0, 5, 4, mk(7'b0000101, 3'b001, 2'b01, 2'b00, 0)});
    tbl.push_back('{8'hFF, 4'h0, 4, 3, mk(7'b0000000, 3'b000, 2'b00, 2'b00, 0)});
    tbl.push_back('{8'h89, 4'h0, 8, 7, mk(7'b0000010, 3'b000, 2'b00, 2'b10, 0)});
    tbl.push_back('{8'h88, 4'h0, 7, 6, mk(7'b0000010, 3'b000, 2'b00, 2'b10, 0)});
    tbl.push_back('{8'h97, 4'h0, 8, 7, mk(7'b0000000, 3'b000, 2'b10, 2'b00, 1)});
    tbl.push_back('{8'h27, 4'h1, 6, 5, mk(7'b0010000, 3'b000, 2'b00, 2'b10, 0)});
    tbl.push_back('{8'h28, 4'h1, 6, 5, mk(7'b0001000, 3'b000, 2'b00, 2'b00, 0)});
    tbl.push_back('{8'h24, 4'hB, 6, 5, mk(7'b0010000, 3'b000, 2'b00, 2'b10, 0)});
    tbl.push_back('{8'h20, 4'h0, 6, 5, mk(7'b0010000, 3'b000, 2'b00, 2'b10, 0)});
    tbl.push_back('{8'h49, 4'h0, 5, 4, mk(7'b0000011, 3'b101, 2'b10, 2'b00, 0)});
    tbl.push_back('{8'h46, 4'h0, 5, 4, mk(7'b0000101, 3'b100, 2'b01, 2'b00, 0)});
    tbl.push_back('{8'h00, 4'h0, 4, 0, F0});

    valid_ops = '{8'h86, 8'h88, 8'h87, 8'h89, 8'h96, 8'h97, 8'h42, 8'h43, 8'h44,
                  8'h45, 8'h46, 8'h47, 8'h48, 8'h49, 8'h20, 8'h23, 8'h24, 8'h27, 8'h28};

    reset = 1'b0;
    bus.IR = 8'h00;
    bus.CCR_Result = 4'h0;
    #3 check("reset_async", dut_out(), F0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_held", dut_out(), F0);
    reset = 1'b1;

    foreach (tbl[i])
      run_instr(tbl[i].ir, tbl[i].ccr, tbl[i].len, 0, 0, 1, tbl[i].chk_k, tbl[i].chk);

    // Store abandoned by reset in S_DIR_6.
    run_instr(8'h97, 4'h0, 6, 0, 0, 0, 0, F0);
    #1 check("dir6_before_rst", dut_out(), exp_out(8'h97, 4'h0, 6));
    reset = 1'b0;
    #1 check("rst_mid_async", dut_out(), F0);
    @(posedge clock);
    @(negedge clock);
    check("rst_mid_held", dut_out(), F0);
    reset = 1'b1;
    run_instr(8'h97, 4'h0, 8, 0, 0, 0, 0, F0);

    // Random instruction stream with flags changing every cycle.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) op = 8'($urandom);
      else                           op = valid_ops[$urandom_range(0, 18)];
      run_instr(op, 4'($urandom), exp_len(op), 0, 1, 0, 0, F0);
    end

    n_cmp++;
    if (wr_seen != wr_exp) begin
      n_bad++;
      $display("FAIL write_count: got %0d expected %0d", wr_seen, wr_exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
